// File: rtl/btb_pkg.sv
// Shared types and slicing helpers for the branch target buffer.
package btb_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;
    localparam ctr_t CTR_ALLOC = WT;

    // PC[1:0] is dropped because fetch addresses are word aligned.
    localparam int IDX_LSB = 2;

    function automatic int tag_lsb(input int idx_w);
        return idx_w + IDX_LSB;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import btb_pkg::*;
(
    input  ctr_t ctr_in,
    input  logic taken,
    output ctr_t ctr_out
);

    always_comb begin
        ctr_out = ctr_in;
        case (ctr_in)
            SNT: ctr_out = taken ? WNT : SNT;
            WNT: ctr_out = taken ? WT  : SNT;
            WT:  ctr_out = taken ? ST  : WNT;
            ST:  ctr_out = taken ? ST  : WT;
        endcase
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB: zero-latency lookup for the next-PC mux, trained from EX.
// Optional macro BTB_BYPASS_EN forwards a same-cycle matching update to the lookup outputs.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 3,
    parameter int TAG_W  = ADDR_W - IDX_W - 2
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Enable,
    input  logic [ADDR_W-1:0] FetchPC,
    output logic              PredHit,
    output logic              PredSel,
    output logic [ADDR_W-1:0] PredTarget,
    input  logic              UpdValid,
    input  logic [ADDR_W-1:0] UpdPC,
    input  logic              UpdTaken,
    input  logic [ADDR_W-1:0] UpdTarget
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_LSB = tag_lsb(IDX_W);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    ctr_t              ctr_q    [ENTRIES];

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             u_hit;
    ctr_t             upd_ctr;

    logic             rd_hit;
    ctr_t             rd_ctr;
    logic [ADDR_W-1:0] rd_target;

    logic unused_lsbs;

    assign f_idx = FetchPC[TAG_LSB-1:IDX_LSB];
    assign f_tag = FetchPC[ADDR_W-1:TAG_LSB];
    assign u_idx = UpdPC[TAG_LSB-1:IDX_LSB];
    assign u_tag = UpdPC[ADDR_W-1:TAG_LSB];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign unused_lsbs = ^{FetchPC[IDX_LSB-1:0], UpdPC[IDX_LSB-1:0]};

    sat_counter2 u_upd_ctr (
        .ctr_in  (ctr_q[u_idx]),
        .taken   (UpdTaken),
        .ctr_out (upd_ctr)
    );

    // UpdValid is a single-cycle strobe with no ready: every reported branch is absorbed at the next edge.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (UpdValid) begin
            if (u_hit) begin
                ctr_q[u_idx] <= upd_ctr;
                if (UpdTaken) target_q[u_idx] <= UpdTarget;
            end else if (UpdTaken) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= UpdTarget;
                ctr_q[u_idx]    <= CTR_ALLOC;
            end
        end
    end

`ifdef BTB_BYPASS_EN
    ctr_t byp_ctr;

    sat_counter2 u_byp_ctr (
        .ctr_in  (ctr_q[f_idx]),
        .taken   (UpdTaken),
        .ctr_out (byp_ctr)
    );
`endif

    always_comb begin
        rd_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        rd_ctr    = ctr_q[f_idx];
        rd_target = target_q[f_idx];
`ifdef BTB_BYPASS_EN
        // Same index and tag means the update hits exactly when the lookup hits.
        if (UpdValid && (u_idx == f_idx) && (u_tag == f_tag)) begin
            if (rd_hit) begin
                rd_ctr = byp_ctr;
                if (UpdTaken) rd_target = UpdTarget;
            end else if (UpdTaken) begin
                rd_hit    = 1'b1;
                rd_ctr    = CTR_ALLOC;
                rd_target = UpdTarget;
            end
        end
`endif
    end

    assign PredHit    = rd_hit;
    assign PredSel    = Enable & rd_hit & rd_ctr[1];
    assign PredTarget = rd_hit ? rd_target : '0;

endmodule
